cla_chunk_sequencer: RTL and testbench
======================================

// Module: cla_chunk_sequencer
// PURPOSE
//  Multi-cycle wide adder that time-shares one CHUNK-bit carry-lookahead slice across WIDTH-bit operands.
//  The slice generates p/g, lookahead carries and sum bits z = p ^ c.
//  The FSM feeds the slice one chunk per cycle, LSB chunk first, and registers the inter-chunk carry.
//  Sits between an operand producer and a result consumer, with valid/ready on both sides.
// PARAMETERS
//  WIDTH  32  operand/result width; WIDTH % CHUNK == 0 required (elaboration error otherwise)
//  CHUNK  4   slice width processed per cycle; NCHUNK = WIDTH/CHUNK
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands a/b/cin valid
//  in_ready   out  1      block can accept operands (IDLE only)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in to chunk 0
//  out_valid  out  1      sum/cout valid (DONE only)
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result a+b+cin
//  cout       out  1      carry out of MSB chunk
//  busy       out  1      high in RUN and DONE
//  ovf        out  1      signed overflow (present only with CLA_OVF_EN)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, idx=0, carry=0, sum=0, cout=0, out_valid=0, busy=0, ovf=0.
//    in_ready=1 after reset release. A partial result in flight is discarded.
//  - States:
//    IDLE: in_ready=1. On in_valid&in_ready, latch a, b, cin; carry<=cin, idx<=0; go to RUN.
//    RUN: each cycle the slice adds a[idx*CHUNK+:CHUNK] + b[same] + carry.
//      Chunk result is written to sum[idx*CHUNK+:CHUNK]; carry <= slice cout; idx++.
//      At idx==NCHUNK-1: cout <= slice cout; go to DONE.
//    DONE: out_valid=1; sum/cout/ovf held stable. On out_ready go to IDLE.
//  - Latency: out_valid rises exactly NCHUNK clock edges after the accept edge (8 at defaults).
//  - Throughput: one result per NCHUNK+2 cycles minimum. No accept in DONE, even while out_ready=1.
//  - in_valid in RUN/DONE is ignored (in_ready=0). Operands are captured only at the accept edge;
//    later changes on a/b have no effect.
//  - sum is undefined-but-deterministic (partially updated) while in RUN. It is qualified only by out_valid.
//    After the handshake, sum/cout hold until the next accept.
//  - Carry wrap: carry chains across all chunks with no truncation.
//    Full-width overflow appears only on cout; sum wraps mod 2^WIDTH.
//  - out_ready while not in DONE: no effect.
// CONFIGURATION
//  CLA_OVF_EN defined: port ovf present. At the last chunk, ovf <= carry into MSB ^ slice cout.
//    ovf is valid with out_valid and cleared on accept.
//  Not defined: no ovf port or logic; all other behaviour identical.
// STRUCTURE
//  - Shared header cla_defs.vh holds: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2),
//    default WIDTH/CHUNK, and the NCHUNK and idx-width ($clog2) constants.
//  - Sub-module cla_slice (CHUNK-bit p/g/carry/sum slice; ports a, b, c, z, cout, c_msb)
//    is instantiated once and reused by the chunk cells of the full adder.
//  - Top: FSM, idx counter, carry register, operand registers, result register.
// TESTING
//  1 Reset: assert rst mid-cycle -> all outputs 0 immediately; in_ready=1 after release.
//  2 a=0x0000_0001, b=0xFFFF_FFFF, cin=0 -> after 8 edges out_valid=1, sum=0x0000_0000, cout=1
//    (carry ripples through all chunks).
//  3 a=0x1234_5678, b=0x1111_1111, cin=1 -> sum=0x2345_678A, cout=0, latency 8 edges.
//  4 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout stable; in_ready=0;
//    new in_valid ignored.
//  5 Reset during RUN at idx=3 -> IDLE, out_valid=0 with no result emitted.
//    Next transaction 5+7 -> sum=12, cout=0.
//  6 CLA_OVF_EN: 0x7FFF_FFFF+0x1 -> ovf=1, cout=0; 0xFFFF_FFFF+0x1 -> ovf=0, cout=1, sum=0.

Source files
------------

// File: rtl/cla_chunk_sequencer_pkg.sv
// cla_chunk_sequencer_pkg
//   Shared constants for the chunked carry-lookahead adder:
//   FSM state encodings, default operand/chunk widths and the idx counter
//   width helper.
//   Optional feature macro used by the design files: CLA_OVF_EN.
// Ports: none (package).
package cla_chunk_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_CHUNK  = 4;
  localparam int DEF_NCHUNK = DEF_WIDTH / DEF_CHUNK;

  // Width of a counter indexing n chunks; a single chunk still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_chunk_sequencer_slice.sv
// cla_slice
//   W-bit carry-lookahead slice. Generates p = a ^ b, g = a & b, every
//   internal carry directly from p/g/c (no ripple), and sum bits z = p ^ c.
// Ports:
//   a, b   in   W   chunk operands
//   c      in   1   carry into bit 0
//   z      out  W   chunk sum
//   cout   out  1   carry out of bit W-1
//   c_msb  out  1   carry into bit W-1 (for signed overflow detection)
module cla_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c,
  output logic [W-1:0] z,
  output logic         cout,
  output logic         c_msb
);

  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W:0]   carry;

  assign p = a ^ b;
  assign g = a & b;

  // carry[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]c, each term built
  // from the propagate/generate vectors alone.
  always_comb begin
    logic term;
    logic acc;
    term  = 1'b0;
    acc   = 1'b0;
    carry = '0;
    carry[0] = c;
    for (int i = 1; i <= W; i++) begin
      term = c;
      for (int k = 0; k < i; k++) term = term & p[k];
      acc = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        acc = acc | term;
      end
      carry[i] = acc;
    end
  end

  assign z     = p ^ carry[W-1:0];
  assign cout  = carry[W];
  assign c_msb = carry[W-1];

endmodule

// File: rtl/cla_chunk_sequencer.sv
// cla_chunk_sequencer
//   Multi-cycle WIDTH-bit adder that reuses one CHUNK-bit lookahead slice,
//   one chunk per cycle, LSB chunk first, with a registered inter-chunk
//   carry. valid/ready handshakes on both the operand and result side.
//   Optional macro CLA_OVF_EN adds the signed-overflow output ovf.
// Ports:
//   clk, rst               clock (rising edge), async active-high reset
//   in_valid/in_ready      operand handshake (ready only in IDLE)
//   a, b, cin              operands, captured at the accept edge
//   out_valid/out_ready    result handshake (valid only in DONE)
//   sum, cout              result a+b+cin, held until the next accept
//   busy                   high in RUN and DONE
//   ovf                    signed overflow (CLA_OVF_EN builds only)
module cla_chunk_sequencer
  import cla_chunk_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef CLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = idx_width(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("cla_chunk_sequencer: WIDTH must be a multiple of CHUNK");
  end

  logic [1:0]       state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  // Chunk views of the captured operands, selected by idx.
  logic [CHUNK-1:0] a_chunk [NCHUNK];
  logic [CHUNK-1:0] b_chunk [NCHUNK];

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
    assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
    assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
  end

  logic [CHUNK-1:0] slice_z;
  logic             slice_cout;
`ifdef CLA_OVF_EN
  logic             slice_c_msb;
  logic             ovf_reg;
`else
  logic             slice_c_msb_unused;
`endif

  cla_slice #(.W(CHUNK)) u_slice (
    .a     (a_chunk[idx_reg]),
    .b     (b_chunk[idx_reg]),
    .c     (carry_reg),
    .z     (slice_z),
    .cout  (slice_cout),
`ifdef CLA_OVF_EN
    .c_msb (slice_c_msb)
`else
    .c_msb (slice_c_msb_unused)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
`ifdef CLA_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
            state_reg <= ST_RUN;
`ifdef CLA_OVF_EN
            ovf_reg   <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (idx_reg == IDX_W'(i)) sum_reg[i*CHUNK +: CHUNK] <= slice_z;
          end
          carry_reg <= slice_cout;
          if (idx_reg == LAST_IDX) begin
            idx_reg   <= '0;
            cout_reg  <= slice_cout;
            state_reg <= ST_DONE;
`ifdef CLA_OVF_EN
            ovf_reg   <= slice_c_msb ^ slice_cout;
`endif
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // in_ready is masked while reset is held so the upstream sees it rise
  // only once reset has been released.
  assign in_ready  = (state_reg == ST_IDLE) && !rst;
  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg == ST_RUN) || (state_reg == ST_DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
`ifdef CLA_OVF_EN
  assign ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_cla_chunk_sequencer.sv
// tb_cla_chunk_sequencer
//   Directed bench for cla_chunk_sequencer with a transaction-level model
//   (a+b+cin computed arithmetically, result due NCHUNK edges after accept)
//   checked every cycle, plus hand-computed literal expectations.
//   Build with CLA_OVF_EN defined to also exercise the ovf output.
module tb_cla_chunk_sequencer;

  localparam int WIDTH = 32;
  localparam int N     = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef CLA_OVF_EN
  logic             ovf;
`endif

  cla_chunk_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef CLA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result model: {ovf, cout, sum} of a+b+cin by plain arithmetic.
  function automatic logic [WIDTH+1:0] model_add(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic c);
    logic [WIDTH:0] full;
    logic           sov;
    full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    sov  = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    return {sov, full};
  endfunction

  // phase: -1 = waiting for operands, 0..N-1 = edges since accept, N = result due.
  int               phase = -1;
  logic [WIDTH-1:0] m_sum = '0;
  logic             m_cout = 1'b0;
  logic             m_ovf = 1'b0;
  logic [WIDTH+1:0] m_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase  <= -1;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
    end else if (phase < 0) begin
      if (in_valid) begin
        phase  <= 0;
        m_pend <= model_add(a, b, cin);
        m_ovf  <= 1'b0;
      end
    end else if (phase < N) begin
      phase <= phase + 1;
      if (phase == N - 1) begin
        m_sum  <= m_pend[WIDTH-1:0];
        m_cout <= m_pend[WIDTH];
        m_ovf  <= m_pend[WIDTH+1];
      end
    end else if (out_ready) begin
      phase <= -1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("cmp_out_valid", out_valid, phase == N);
      check("cmp_in_ready", in_ready, phase < 0);
      check("cmp_busy", busy, phase >= 0);
      if (phase < 0 || phase == N) begin
        check("cmp_sum", sum, m_sum);
        check("cmp_cout", cout, m_cout);
      end
`ifdef CLA_OVF_EN
      check("cmp_ovf", ovf, m_ovf);
`endif
    end
  end

  task automatic txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                     input logic tc, input int hold,
                     input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int lat;
    @(posedge clk);
    #2;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    check("pre_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~ta; b = $urandom; cin = ~tc;
    check("model_sum", m_pend[WIDTH-1:0], es);
    check("model_cout", m_pend[WIDTH], ec);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    check("latency", lat, N);
    check("res_sum", sum, es);
    check("res_cout", cout, ec);
`ifdef CLA_OVF_EN
    check("res_ovf", ovf, eo);
`else
    if (eo !== 1'b0 && eo !== 1'b1) check("eo_known", eo, 1'b0);
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom;
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_sum", sum, es);
      check("hold_cout", cout, ec);
      check("hold_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_valid", out_valid, 1'b0);
    check("post_sum", sum, es);
    check("post_in_ready", in_ready, 1'b1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_sum"}, sum, '0);
    check({tag, "_cout"}, cout, 1'b0);
`ifdef CLA_OVF_EN
    check({tag, "_ovf"}, ovf, 1'b0);
`endif
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    #1 check("rel_in_ready", in_ready, 1'b1);

    // Mid-cycle reset while idle.
    @(posedge clk);
    #3 rst = 1'b1;
    #1 reset_checks("rst_idle");
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("rel2_in_ready", in_ready, 1'b1);

    // Carry ripples through every chunk.
    txn(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0, 32'h0000_0000, 1'b1, 1'b0);
    txn(32'h1234_5678, 32'h1111_1111, 1'b1, 0, 32'h2345_678A, 1'b0, 1'b0);
    // Backpressure for 5 cycles with in_valid pulsing.
    txn(32'hDEAD_BEEF, 32'h1000_0001, 1'b0, 5, 32'hEEAD_BEF0, 1'b0, 1'b0);
    txn(32'h8000_0000, 32'h8000_0000, 1'b0, 1, 32'h0000_0000, 1'b1, 1'b1);
    txn(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 32'h0000_0000, 1'b1, 1'b0);
    txn(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 2, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Reset during RUN at idx=3: no result may appear.
    @(posedge clk);
    #2;
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1 reset_checks("rst_run");
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("rel3_in_ready", in_ready, 1'b1);
    repeat (N + 2) begin
      @(posedge clk);
      #1 check("no_stale_valid", out_valid, 1'b0);
    end
    txn(32'd5, 32'd7, 1'b0, 0, 32'd12, 1'b0, 1'b0);

`ifdef CLA_OVF_EN
    txn(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h8000_0000, 1'b0, 1'b1);
    txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h0000_0000, 1'b1, 1'b0);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
